pipeline_hazard_ctrl: RTL and testbench

Backward-direction control for the 5-stage pipeline. It consumes stage-tagged destination and source information from the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It returns write-enable, flush and forwarding-select controls to those registers and to the PC. It covers load-use stalls, taken-branch flushes, multi-cycle data-memory freezes (including a branch that resolves during a freeze) and a freeze-timeout error.

---
 rtl/pipeline_hazard_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall, flush, freeze and forwarding control for the
// 5-stage pipeline. Build with HAZARD_PERF_EN defined to add saturating
// perf counters for load-use bubbles, flushes and freeze cycles.
module pipeline_hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int CNT_W        = 16,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             wb_reg_write,
  input  logic             mem_wait,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             id_ex_write_en,
  output logic             ex_mem_write_en,
  output logic             mem_wb_write_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt,
  output logic [CNT_W-1:0] perf_freeze_cnt
`endif
);

  typedef enum logic [1:0] {RUN = 2'd0, FREEZE = 2'd1} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(WAIT_TIMEOUT);

  state_t           state_q, state_d;
  logic             branch_pend_q, branch_pend_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;

  logic lu, br;
  logic stall_cyc, flush_cyc, freeze_cyc;
  // raw (un-gated) control decisions
  logic pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_fl, idex_fl;
  logic [1:0] fwd_a, fwd_b;

  // State, pending-branch, freeze counter and sticky timeout registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      branch_pend_q <= 1'b0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      branch_pend_q <= branch_pend_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Next state and hazard controls. A held memory overrides everything;
  // the first cycle with mem_wait low is resolved with the RUN rules, so a
  // branch latched on freeze entry flushes exactly then.
  always_comb begin
    lu = ex_mem_read & ex_reg_write & (ex_dest != '0) &
         ((id_uses_rs & (id_rs == ex_dest)) | (id_uses_rt & (id_rt == ex_dest)));
    br = branch_taken | branch_pend_q;

    state_d       = state_q;
    branch_pend_d = branch_pend_q;
    wait_cnt_d    = wait_cnt_q;
    pc_we         = 1'b1;
    ifid_we       = 1'b1;
    idex_we       = 1'b1;
    exmem_we      = 1'b1;
    memwb_we      = 1'b1;
    ifid_fl       = 1'b0;
    idex_fl       = 1'b0;
    stall_cyc     = 1'b0;
    flush_cyc     = 1'b0;
    freeze_cyc    = 1'b0;

    if (mem_wait) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
      if (state_q == RUN) begin
        // EX is held from here on, so branch_taken is only captured now
        state_d    = FREEZE;
        wait_cnt_d = '0;
        if (branch_taken) branch_pend_d = 1'b1;
      end else begin
        freeze_cyc = 1'b1;
        if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end else begin
      state_d    = RUN;
      wait_cnt_d = '0;
      if (br) begin
        // the load-use victim (if any) is squashed, so no stall is needed
        ifid_fl       = 1'b1;
        idex_fl       = 1'b1;
        branch_pend_d = 1'b0;
        flush_cyc     = 1'b1;
      end else if (lu) begin
        pc_we     = 1'b0;
        ifid_we   = 1'b0;
        idex_fl   = 1'b1;
        stall_cyc = 1'b1;
      end
    end

    mem_timeout_d = mem_timeout_q | (freeze_cyc & (wait_cnt_d >= TIMEOUT));
  end

  // Operand forwarding; the younger EX/MEM result wins over MEM/WB
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_reg_write && mem_dest != '0 && mem_dest == ex_rs)     fwd_a = 2'b01;
    else if (wb_reg_write && wb_dest != '0 && wb_dest == ex_rs)   fwd_a = 2'b10;
    if (mem_reg_write && mem_dest != '0 && mem_dest == ex_rt)     fwd_b = 2'b01;
    else if (wb_reg_write && wb_dest != '0 && wb_dest == ex_rt)   fwd_b = 2'b10;
  end

  // While reset is held the outputs show RUN defaults immediately, even if
  // the memory is still reporting busy.
  always_comb begin
    pc_write_en     = 1'b1;
    if_id_write_en  = 1'b1;
    id_ex_write_en  = 1'b1;
    ex_mem_write_en = 1'b1;
    mem_wb_write_en = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    fwd_a_sel       = 2'b00;
    fwd_b_sel       = 2'b00;
    if (reset) begin
      pc_write_en     = pc_we;
      if_id_write_en  = ifid_we;
      id_ex_write_en  = idex_we;
      ex_mem_write_en = exmem_we;
      mem_wb_write_en = memwb_we;
      if_id_flush     = ifid_fl;
      id_ex_flush     = idex_fl;
      fwd_a_sel       = fwd_a;
      fwd_b_sel       = fwd_b;
    end
  end

  assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
  logic [CNT_W-1:0] perf_flush_q, perf_flush_d;
  logic [CNT_W-1:0] perf_freeze_q, perf_freeze_d;

  // Saturating event counters
  always_comb begin
    perf_stall_d  = perf_stall_q;
    perf_flush_d  = perf_flush_q;
    perf_freeze_d = perf_freeze_q;
    if (stall_cyc  && perf_stall_q  != '1) perf_stall_d  = perf_stall_q  + 1'b1;
    if (flush_cyc  && perf_flush_q  != '1) perf_flush_d  = perf_flush_q  + 1'b1;
    if (freeze_cyc && perf_freeze_q != '1) perf_freeze_d = perf_freeze_q + 1'b1;
  end

  // Perf counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q  <= '0;
      perf_flush_q  <= '0;
      perf_freeze_q <= '0;
    end else begin
      perf_stall_q  <= perf_stall_d;
      perf_flush_q  <= perf_flush_d;
      perf_freeze_q <= perf_freeze_d;
    end
  end

  assign perf_stall_cnt  = perf_stall_q;
  assign perf_flush_cnt  = perf_flush_q;
  assign perf_freeze_cnt = perf_freeze_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (WAIT_TIMEOUT=3).
module tb_pipeline_hazard_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset;
  logic [REG_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
  logic id_uses_rs, id_uses_rt, ex_reg_write, ex_mem_read, branch_taken;
  logic mem_reg_write, wb_reg_write, mem_wait;
  logic pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en, mem_wb_write_en;
  logic if_id_flush, id_ex_flush, mem_timeout;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [6:0] ctl;

  int tests = 0;
  int fails = 0;

  // control vector: {pc, if_id, id_ex, ex_mem, mem_wb write enables, if_id_flush, id_ex_flush}
  localparam logic [6:0] C_NORM   = 7'b11111_00;
  localparam logic [6:0] C_STALL  = 7'b00111_01;
  localparam logic [6:0] C_FLUSH  = 7'b11111_11;
  localparam logic [6:0] C_FROZEN = 7'b00000_00;

  assign ctl = {pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en,
                mem_wb_write_en, if_id_flush, id_ex_flush};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .WAIT_TIMEOUT(3)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
    .mem_dest(mem_dest), .mem_reg_write(mem_reg_write),
    .wb_dest(wb_dest), .wb_reg_write(wb_reg_write), .mem_wait(mem_wait),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .id_ex_write_en(id_ex_write_en), .ex_mem_write_en(ex_mem_write_en),
    .mem_wb_write_en(mem_wb_write_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mem_timeout(mem_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // move to 2 time units after the next rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0;
    {id_rs, id_rt, ex_rs, ex_rt, ex_dest, mem_dest, wb_dest} = '0;
    {id_uses_rs, id_uses_rt, ex_reg_write, ex_mem_read, branch_taken} = '0;
    {mem_reg_write, wb_reg_write, mem_wait} = '0;
    #1;
    chk("reset_ctl", 32'(ctl), 32'(C_NORM));
    chk("reset_fwd", {28'd0, fwd_a_sel, fwd_b_sel}, 32'd0);
    chk("reset_timeout", 32'(mem_timeout), 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // load-use on rs: one bubble, then the load has moved on
    ex_mem_read = 1; ex_reg_write = 1; ex_dest = 5; id_rs = 5; id_uses_rs = 1;
    #1 chk("lu_rs_stall", 32'(ctl), 32'(C_STALL));
    tick();
    ex_mem_read = 0; ex_reg_write = 0; ex_dest = 0;
    #1 chk("lu_one_cycle", 32'(ctl), 32'(C_NORM));
    // ex_dest=0 never matches
    ex_mem_read = 1; ex_reg_write = 1; ex_dest = 0; id_rs = 0;
    #1 chk("lu_r0_nostall", 32'(ctl), 32'(C_NORM));
    // load-use on rt
    id_uses_rs = 0; id_uses_rt = 1; id_rt = 9; ex_dest = 9;
    #1 chk("lu_rt_stall", 32'(ctl), 32'(C_STALL));
    id_uses_rt = 0;
    #1 chk("lu_rt_unused", 32'(ctl), 32'(C_NORM));
    id_uses_rt = 1;

    // taken branch beats load-use
    branch_taken = 1;
    #1 chk("br_over_lu", 32'(ctl), 32'(C_FLUSH));
    tick();
    branch_taken = 0; ex_mem_read = 0; ex_reg_write = 0; id_uses_rt = 0; ex_dest = 0;
    #1 chk("br_no_pend", 32'(ctl), 32'(C_NORM));
    tick();

    // 4-cycle freeze with branch on the first; flush on release
    mem_wait = 1; branch_taken = 1;
    #1 chk("frz_c1", 32'(ctl), 32'(C_FROZEN));
    tick(); branch_taken = 0;
    #1 chk("frz_c2", 32'(ctl), 32'(C_FROZEN));
    tick();
    #1 chk("frz_c3", 32'(ctl), 32'(C_FROZEN));
    tick();
    #1 chk("frz_c4", 32'(ctl), 32'(C_FROZEN));
    tick(); mem_wait = 0;
    #1 chk("frz_release_flush", 32'(ctl), 32'(C_FLUSH));
    chk("frz_timeout_set", 32'(mem_timeout), 32'd1);
    tick();
    #1 chk("frz_after_flush", 32'(ctl), 32'(C_NORM));
    reset = 0;
    #1 chk("timeout_reset_clear", 32'(mem_timeout), 32'd0);
    tick(); reset = 1;
    tick();

    // forwarding
    ex_rs = 7; mem_dest = 7; mem_reg_write = 1; wb_dest = 7; wb_reg_write = 1;
    #1 chk("fwd_a_exmem", 32'(fwd_a_sel), 32'd1);
    mem_wait = 1;
    #1 chk("fwd_during_wait", 32'(fwd_a_sel), 32'd1);
    mem_wait = 0;
    mem_reg_write = 0;
    #1 chk("fwd_a_memwb", 32'(fwd_a_sel), 32'd2);
    wb_dest = 0;
    #1 chk("fwd_a_r0", 32'(fwd_a_sel), 32'd0);
    ex_rt = 3; mem_dest = 3; mem_reg_write = 1; wb_dest = 3;
    #1 chk("fwd_b_exmem", 32'(fwd_b_sel), 32'd1);
    chk("fwd_a_nomatch", 32'(fwd_a_sel), 32'd0);
    ex_rs = 0; mem_dest = 0;
    #1 chk("fwd_b_memwb", 32'(fwd_b_sel), 32'd2);
    chk("fwd_a_dest0", 32'(fwd_a_sel), 32'd0);
    {ex_rs, ex_rt, mem_dest, wb_dest, mem_reg_write, wb_reg_write} = '0;
    tick();

    // timeout: 5 held cycles, timeout visible after 3 FREEZE cycles
    mem_wait = 1;
    #1 chk("to_c1", 32'(mem_timeout), 32'd0);
    tick();
    #1 chk("to_c2", 32'(mem_timeout), 32'd0);
    tick();
    #1 chk("to_c3", 32'(mem_timeout), 32'd0);
    tick();
    #1 chk("to_c4", 32'(mem_timeout), 32'd0);
    tick();
    #1 chk("to_c5", 32'(mem_timeout), 32'd1);
    chk("to_still_frozen", 32'(ctl), 32'(C_FROZEN));
    tick(); mem_wait = 0;
    #1 chk("to_sticky", 32'(mem_timeout), 32'd1);
    chk("to_release_noflush", 32'(ctl), 32'(C_NORM));
    tick();
    #1 chk("to_sticky2", 32'(mem_timeout), 32'd1);
    reset = 0;
    #1 chk("to_cleared", 32'(mem_timeout), 32'd0);
    tick(); reset = 1;
    tick();

    // reset in the middle of a freeze with a pending branch
    mem_wait = 1; branch_taken = 1;
    tick(); branch_taken = 0;
    #1 chk("rst_frz_frozen", 32'(ctl), 32'(C_FROZEN));
    reset = 0;
    #1 chk("rst_frz_async", 32'(ctl), 32'(C_NORM));
    tick(); mem_wait = 0;
    tick(); reset = 1;
    #1 chk("rst_frz_no_flush", 32'(ctl), 32'(C_NORM));
    tick();
    #1 chk("rst_frz_no_flush2", 32'(ctl), 32'(C_NORM));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
